// File: rtl/perceptron_job_arbiter.sv
// perceptron_job_arbiter: round-robin arbiter sharing one perceptron training node with start/ready handshake and timeout abort
module perceptron_job_arbiter #(
  parameter int N = 4,
  parameter int IDX_W = 2,
  parameter int TO_W = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     done,
  output logic             err,
  output logic             busy,
  input  logic             core_ready,
  output logic             core_start
);
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, FINISH} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, win, off;
  logic [N-1:0] rot;
  logic [IDX_W:0] sum;
  logic [TO_W-1:0] cnt;
  logic err_r, go, active, leave, to_hit;
  assign go = state == IDLE && |req && core_ready;
  assign active = state == ISSUE || state == RUN;
  assign leave = (state == ISSUE && !core_ready) || (state == RUN && core_ready);
  assign to_hit = cnt == TO_W'(TIMEOUT - 1);
  // winner: first set req bit scanning upward from the pointer, wrapping
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    win = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : sum[IDX_W-1:0];
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: a normal handshake exit takes precedence over the timeout
  always_comb begin
    state_n = state == IDLE  ? (go ? ISSUE : IDLE) :
              state == ISSUE ? (!core_ready ? RUN : to_hit ? FINISH : ISSUE) :
              state == RUN   ? (core_ready || to_hit ? FINISH : RUN) : IDLE;
  end
  // grant, pointer, timeout counter and abort flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant <= '0;
      grant_idx <= '0;
      ptr <= '0;
      cnt <= '0;
      err_r <= 1'b0;
    end else begin
      if (go) begin
        grant <= N'(1) << win;
        grant_idx <= win;
        cnt <= '0;
        err_r <= 1'b0;
      end
      if (active) begin
        cnt <= cnt + TO_W'(1);
        err_r <= to_hit && !leave;
      end
      if (state == FINISH) begin
        grant <= '0;
        grant_idx <= '0;
        ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  // outputs decoded from registered state only
  always_comb begin
    core_start = state == ISSUE;
    busy = state != IDLE;
    done = (state == FINISH) ? grant : '0;
    err = state == FINISH && err_r;
  end
endmodule
